// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state type and
// default datapath widths.
package fib_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fib_core.sv
// Fibonacci datapath: holds the current pair (a, b) and a flag recording
// whether the most recent addition that produced b carried out of WIDTH bits.
module fib_core
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic             b_ovf
);

    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;

    // Sum is formed one bit wider so the carry lands in the MSB.
    assign sum = {1'b0, a} + {1'b0, b};

    // Pair register: reset/clear to (0, 1), otherwise advance one term per step.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            a     <= '0;
            b     <= WIDTH'(1);
            b_ovf <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            b_ovf <= sum[WIDTH];
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// Run controller for fib_core: accepts a counted request, streams terms over
// a valid/ready handshake, and ends a run early when the next term would not
// fit in WIDTH bits.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             abort,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             ovf
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             b_ovf;
    logic             handshake;
    logic             last_term;
    logic             core_clear;
    logic             core_step;

    // An aborted cycle never counts as a delivery, even if ready was high.
    assign handshake  = (state == RUN) && out_valid && out_ready && !abort;
    assign last_term  = (remaining == CNT_W'(1));
    assign core_clear = (state == IDLE) && start && (n_terms != '0);
    // Only advance the core when the run continues; the final term stays on out_data.
    assign core_step  = handshake && !last_term && !b_ovf;
    assign busy       = (state == RUN);

    fib_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (core_clear),
        .step  (core_step),
        .a     (out_data),
        .b_ovf (b_ovf)
    );

    // Run FSM with registered valid/done/ovf and the remaining-term counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ovf <= 1'b0;
                        if (n_terms != '0) begin
                            remaining <= n_terms;
                            out_valid <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (handshake) begin
                        remaining <= remaining - CNT_W'(1);
                        if (last_term) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else if (b_ovf) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            ovf       <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
